// File: rtl/mplier_u8x8.sv
// Unsigned 8x8 -> 16-bit multiplier: AND-array partial products, Wallace-style
// 3:2 carry-save reduction, ripple carry-propagate adder, registered output.
module mplier_u8x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        in_valid,
    output logic [15:0] product,
    output logic        out_valid
);

    localparam int unsigned OPW = 8;
    localparam int unsigned PW  = 16;

    logic [PW-1:0] w_pp [OPW];

    // Partial-product row i is a gated by b[i], aligned at column i.
    for (genvar i = 0; i < OPW; i++) begin : g_pp
        assign w_pp[i] = PW'({8'h00, a & {OPW{b[i]}}}) << i;
    end

    // Each 3:2 stage is a row of full adders. Carries leaving column 15 are
    // dropped: the sum is exact modulo 2^16 and the true product never
    // reaches 2^16, so nothing is lost.
    logic [PW-1:0] w_s0, w_c0, w_s1, w_c1;
    logic [PW-1:0] w_s2, w_c2, w_s3, w_c3;
    logic [PW-1:0] w_s4, w_c4, w_s5, w_c5;
    logic [PW-1:0] w_m0, w_m1, w_m2, w_m3, w_m4, w_m5;

    // Level 1: 8 rows -> 6 rows
    assign w_s0 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_m0 = (w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2]);
    assign w_c0 = {w_m0[PW-2:0], 1'b0};
    assign w_s1 = w_pp[3] ^ w_pp[4] ^ w_pp[5];
    assign w_m1 = (w_pp[3] & w_pp[4]) | (w_pp[3] & w_pp[5]) | (w_pp[4] & w_pp[5]);
    assign w_c1 = {w_m1[PW-2:0], 1'b0};

    // Level 2: 6 rows -> 4 rows
    assign w_s2 = w_s0 ^ w_c0 ^ w_s1;
    assign w_m2 = (w_s0 & w_c0) | (w_s0 & w_s1) | (w_c0 & w_s1);
    assign w_c2 = {w_m2[PW-2:0], 1'b0};
    assign w_s3 = w_c1 ^ w_pp[6] ^ w_pp[7];
    assign w_m3 = (w_c1 & w_pp[6]) | (w_c1 & w_pp[7]) | (w_pp[6] & w_pp[7]);
    assign w_c3 = {w_m3[PW-2:0], 1'b0};

    // Level 3: 4 rows -> 3 rows
    assign w_s4 = w_s2 ^ w_c2 ^ w_s3;
    assign w_m4 = (w_s2 & w_c2) | (w_s2 & w_s3) | (w_c2 & w_s3);
    assign w_c4 = {w_m4[PW-2:0], 1'b0};

    // Level 4: 3 rows -> 2 rows
    assign w_s5 = w_s4 ^ w_c4 ^ w_c3;
    assign w_m5 = (w_s4 & w_c4) | (w_s4 & w_c3) | (w_c4 & w_c3);
    assign w_c5 = {w_m5[PW-2:0], 1'b0};

    // Final carry-propagate adder built from explicit full-adder cells.
    logic [PW:0]   w_carry;
    logic [PW-1:0] w_sum;

    assign w_carry[0] = 1'b0;
    for (genvar k = 0; k < PW; k++) begin : g_cpa
        assign w_sum[k]     = w_s5[k] ^ w_c5[k] ^ w_carry[k];
        assign w_carry[k+1] = (w_s5[k] & w_c5[k]) | (w_s5[k] & w_carry[k])
                            | (w_c5[k] & w_carry[k]);
    end

    logic [PW-1:0] r_product;
    logic          r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_product   <= w_sum;
            r_out_valid <= in_valid;
        end
    end

    assign product   = r_product;
    assign out_valid = r_out_valid;

    // Final carry out is always 0 for an 8x8 product.
    logic w_unused;
    assign w_unused = w_carry[PW];

endmodule

// File: tb/tb_mplier_u8x8.sv
// Directed, table-driven bench for mplier_u8x8 with sweep, reset and ordering sequences.
module tb_mplier_u8x8;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;
    logic [15:0] product;
    logic        out_valid;

    int checks;
    int failures;

    mplier_u8x8 dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .product  (product),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic        vv;
        logic [15:0] exp_p;
        logic        exp_v;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one sample, then look at the registered result just after the edge.
    task automatic apply(input logic [7:0] ia, input logic [7:0] ib, input logic iv);
        a        = ia;
        b        = ib;
        in_valid = iv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] exp;
        int          sweep_err;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = 8'h00;
        b        = 8'h00;
        in_valid = 1'b0;

        // Corners, then valid tracking 1,0,1,1,0.
        vecs[0] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01, 1'b1};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{8'h01, 8'hB7, 1'b1, 16'h00B7, 1'b1};
        vecs[4] = '{8'd3,  8'd5,  1'b1, 16'd15,   1'b1};
        vecs[5] = '{8'd3,  8'd5,  1'b0, 16'd15,   1'b0};
        vecs[6] = '{8'd12, 8'd10, 1'b1, 16'd120,  1'b1};
        vecs[7] = '{8'd12, 8'd10, 1'b1, 16'd120,  1'b1};
        vecs[8] = '{8'd12, 8'd10, 1'b0, 16'd120,  1'b0};

        #3;
        chk("reset_product", product, 16'h0000);
        chk("reset_valid", 16'(out_valid), 16'h0000);
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_hold_product", product, 16'h0000);
        chk("reset_hold_valid", 16'(out_valid), 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].va, vecs[i].vb, vecs[i].vv);
            chk($sformatf("vec%0d_product", i), product, vecs[i].exp_p);
            chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].exp_v));
        end

        // X on operands while idle must not reach out_valid.
        apply(8'hxx, 8'hxx, 1'b0);
        chk("x_idle_valid", 16'(out_valid), 16'h0000);

        // Async reset between edges while holding FE01 / valid.
        apply(8'hFF, 8'hFF, 1'b1);
        chk("pre_rst_product", product, 16'hFE01);
        chk("pre_rst_valid", 16'(out_valid), 16'h0001);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_product", product, 16'h0000);
        chk("async_rst_valid", 16'(out_valid), 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_held_product", product, 16'h0000);
        rst = 1'b0;
        apply(8'd7, 8'd9, 1'b1);
        chk("post_rst_product", product, 16'd63);
        chk("post_rst_valid", 16'(out_valid), 16'h0001);

        // Back-to-back alternating operands.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) apply(8'hFF, 8'h01, 1'b1);
            else            apply(8'h01, 8'hFF, 1'b1);
            chk("b2b_product", product, 16'h00FF);
            chk("b2b_valid", 16'(out_valid), 16'h0001);
        end

        // Commutativity with reference product computed here.
        for (int i = 0; i < 200; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            exp = 16'(ra) * 16'(rb);
            apply(ra, rb, 1'b1);
            chk("comm_ab", product, exp);
            apply(rb, ra, 1'b1);
            chk("comm_ba", product, exp);
        end

        // Exhaustive sweep, in_valid high every cycle.
        sweep_err = 0;
        for (int i = 0; i < 65536; i++) begin
            ra  = 8'(i >> 8);
            rb  = 8'(i);
            exp = 16'(ra) * 16'(rb);
            apply(ra, rb, 1'b1);
            if (product !== exp || out_valid !== 1'b1) begin
                if (sweep_err < 5)
                    $display("sweep miss a=%h b=%h got %h/%b", ra, rb, product, out_valid);
                sweep_err++;
            end
        end
        chk("sweep_errors", 16'(sweep_err), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mplier_u8x8.md
Name: mplier_u8x8

Overview:
- Unsigned 8x8 -> 16-bit fast multiplier for datapath blocks needing a single-cycle product.
- Combinational core: AND-array partial products, Dadda/Wallace carry-save reduction tree, final 16-bit carry-propagate adder.
- Result and valid flag are registered at the output, giving a fixed 1-cycle latency.

Parameters:
- none (width fixed at 8x8; a wider variant is a separate block)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- in_valid  input  1  a/b qualify this cycle
- product  output  16  registered unsigned a*b
- out_valid  output  1  product holds a fresh result

Behaviour:
- Reset (rst=1, asynchronous, any time): product=16'h0000, out_valid=0 immediately, independent of clk. Both hold while rst=1.
- After rst deasserts, the first capture occurs at the next rising clk edge.
- Each rising clk edge with rst=0:
  - product <= a*b (full 16-bit result; no truncation, no overflow possible since 255*255=65025 < 65536);
  - out_valid <= in_valid.
- product updates every cycle regardless of in_valid. Consumers must qualify it with out_valid.
- Latency: exactly 1 clock, edge k sample -> visible after edge k. Throughput: one product per clock, back-to-back with no bubbles.
- Reset mid-operation: an in-flight result is discarded; no stale product appears after reset.
- Arithmetic: purely unsigned, so bit 7 of a/b is magnitude, not sign.
- Core structure:
  - pp[i][j]=a[j]&b[i] (64 bits);
  - column-wise reduction with full/half adders to two rows;
  - 16-bit adder; carry out of bit 15 is provably 0 and is dropped.
- Core must not use the behavioural '*' operator; it is built from explicit adder cells so timing and structure are controlled.
- Combinational core meets one clock period at the target frequency; no internal pipeline registers.
- X on a/b while in_valid=0 must not propagate to out_valid.

Test Plan:
- Exhaustive sweep: a,b over all 65536 combinations with in_valid=1 every cycle. Product one cycle later equals a*b for every pair; out_valid=1 continuously after the first edge.
- Corners:
  - a=8'hFF, b=8'hFF -> product=16'hFE01 (65025);
  - a=8'h80, b=8'h80 -> 16'h4000;
  - a=8'h00, b=8'hFF -> 16'h0000;
  - a=8'h01, b=8'hB7 -> 16'h00B7.
- Valid tracking: in_valid pattern 1,0,1,1,0 with a=3,b=5 then a=12,b=10. out_valid replays the pattern delayed one cycle; products are 15 and 120 on the corresponding cycles.
- Async reset: assert rst between clock edges while product=16'hFE01, out_valid=1. Both outputs go to 0 before the next edge; after release the next edge with a=7,b=9,in_valid=1 gives product=63, out_valid=1.
- Back-to-back: alternate a=8'hFF,b=8'h01 and a=8'h01,b=8'hFF every cycle. product=16'h00FF each cycle, out_valid stays 1; no glitch captured across cycles.
- Commutativity spot check: 200 random pairs, each also applied swapped (b,a). Identical products in both orders.
